// File: rtl/seq_multiplier_if.sv
// Handshake and register-file bus between execute-stage control and the iterative multiplier.
// Control drives the request side; the multiplier drives status and the write port.
interface seq_multiplier_if #(
  parameter int unsigned WIDTH = 64
) ();
  logic             Start;
  logic             Op;
  logic [WIDTH-1:0] BusA;
  logic [WIDTH-1:0] BusB;
  logic [4:0]       Rd;

  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] BusW;
  logic [4:0]       RW;
  logic             RegWr;

  modport master (
    output Start, Op, BusA, BusB, Rd,
    input  Busy, Done, BusW, RW, RegWr
  );

  modport slave (
    input  Start, Op, BusA, BusB, Rd,
    output Busy, Done, BusW, RW, RegWr
  );
endinterface

// File: rtl/seq_multiplier.sv
// Iterative shift-add unsigned multiplier: one partial product per cycle, fixed WIDTH-cycle run,
// then a one-cycle write-back pulse toward the register file.
module seq_multiplier #(
  parameter int unsigned WIDTH = 64
) (
  input logic            Clk,
  input logic            Reset,
  seq_multiplier_if.slave mul
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] LastIter = CntW'(WIDTH - 1);
  localparam logic [4:0] ZeroReg = 5'd31;

  typedef enum logic [1:0] {StIdle, StRun, StWb} state_e;

  state_e               state_q;
  logic [2*WIDTH-1:0]   mcand_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [2*WIDTH-1:0]   acc_sum;
  logic [WIDTH-1:0]     mplier_q;
  logic [CntW-1:0]      cnt_q;
  logic [4:0]           rd_q;
  logic                 op_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 reg_wr_q;
  logic [WIDTH-1:0]     bus_w_q;
  logic [4:0]           rw_q;

  // Accumulator value after the current iteration; also feeds the result on the last one.
  always_comb begin
    acc_sum = acc_q;
    if (mplier_q[0]) begin
      acc_sum = acc_q + mcand_q;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= StIdle;
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      rd_q     <= '0;
      op_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      reg_wr_q <= 1'b0;
      bus_w_q  <= '0;
      rw_q     <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          done_q   <= 1'b0;
          reg_wr_q <= 1'b0;
          if (mul.Start) begin
            mcand_q  <= {{WIDTH{1'b0}}, mul.BusA};
            mplier_q <= mul.BusB;
            rd_q     <= mul.Rd;
            op_q     <= mul.Op;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= StRun;
          end
        end
        StRun: begin
          acc_q    <= acc_sum;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == LastIter) begin
            // Outputs are registered here so they are valid for the whole WB cycle.
            state_q  <= StWb;
            done_q   <= 1'b1;
            reg_wr_q <= (rd_q != ZeroReg);
            bus_w_q  <= op_q ? acc_sum[2*WIDTH-1:WIDTH] : acc_sum[WIDTH-1:0];
            rw_q     <= rd_q;
          end
        end
        StWb: begin
          done_q   <= 1'b0;
          reg_wr_q <= 1'b0;
          busy_q   <= 1'b0;
          state_q  <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign mul.Busy  = busy_q;
  assign mul.Done  = done_q;
  assign mul.BusW  = bus_w_q;
  assign mul.RW    = rw_q;
  assign mul.RegWr = reg_wr_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed and randomized checks of seq_multiplier against an arithmetic product model,
// with a small register file capturing writes on the negedge.
module tb_seq_multiplier;
  localparam int unsigned W = 64;

  logic Clk = 1'b0;
  logic Reset = 1'b1;
  always #5 Clk = ~Clk;

  seq_multiplier_if #(.WIDTH(W)) bus ();

  seq_multiplier #(.WIDTH(W)) dut (
    .Clk  (Clk),
    .Reset(Reset),
    .mul  (bus)
  );

  int compared = 0;
  int mismatched = 0;

  logic [W-1:0] rf [32];

  always @(negedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (bus.RegWr && bus.RW != 5'd31) begin
      rf[bus.RW] <= bus.BusW;
    end
  end

  function automatic logic [W-1:0] ref_res(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic op);
    logic [2*W-1:0] p;
    p = (2*W)'(a) * (2*W)'(b);
    return op ? p[2*W-1:W] : p[W-1:0];
  endfunction

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [4:0] rd,
                       input logic op, input bit poke, input string tag);
    int n;
    int busy_n;
    logic [W-1:0] exp;
    exp = ref_res(a, b, op);
    @(negedge Clk);
    bus.Start = 1'b1; bus.BusA = a; bus.BusB = b; bus.Rd = rd; bus.Op = op;
    @(negedge Clk);
    // Disturb the operand buses right after acceptance; the snapshot must hold.
    bus.Start = 1'b0; bus.BusA = ~a; bus.BusB = b ^ 64'd1; bus.Rd = rd ^ 5'd1; bus.Op = ~op;
    n = 0;
    busy_n = 0;
    while (!bus.Done && n < 200) begin
      if (bus.Busy) busy_n++;
      if (poke && n == 10) begin
        bus.Start = 1'b1; bus.BusA = 64'd100; bus.BusB = 64'd77;
      end
      if (poke && n == 12) bus.Start = 1'b0;
      @(negedge Clk);
      n++;
    end
    if (bus.Busy) busy_n++;
    check({tag, " latency"}, W'(n), 64'd64);
    check({tag, " BusW"}, bus.BusW, exp);
    check({tag, " RW"}, W'(bus.RW), W'(rd));
    check({tag, " RegWr"}, W'(bus.RegWr), W'(rd != 5'd31));
    @(negedge Clk);
    check({tag, " busy cycles"}, W'(busy_n), 64'd65);
    check({tag, " Done drop"}, W'({bus.Done, bus.RegWr, bus.Busy}), 64'd0);
    check({tag, " BusW hold"}, bus.BusW, exp);
    if (rd != 5'd31) check({tag, " regfile"}, rf[rd], exp);
    repeat (3) @(negedge Clk);
    check({tag, " stays idle"}, W'({bus.Busy, bus.Done}), 64'd0);
  endtask

  initial begin
    int n_done;
    int n_wr;
    int cyc;
    int dones;
    int rises;
    int done_t [2];
    int rise_t [2];
    logic prev_busy;

    bus.Start = 1'b0; bus.Op = 1'b0; bus.BusA = '0; bus.BusB = '0; bus.Rd = '0;
    Reset = 1'b1;
    repeat (3) @(negedge Clk);
    check("reset Busy", W'(bus.Busy), 64'd0);
    check("reset Done/RegWr", W'({bus.Done, bus.RegWr}), 64'd0);
    check("reset BusW", bus.BusW, 64'd0);
    check("reset RW", W'(bus.RW), 64'd0);
    Reset = 1'b0;

    do_op(64'd3, 64'd5, 5'd2, 1'b0, 1'b0, "basic");
    check("basic value", rf[2], 64'd15);
    do_op('1, '1, 5'd7, 1'b1, 1'b0, "umulh max");
    check("umulh value", bus.BusW, 64'hFFFF_FFFF_FFFF_FFFE);
    do_op('1, '1, 5'd7, 1'b0, 1'b0, "mul max");
    check("mul max value", bus.BusW, 64'h1);
    do_op(64'd9, 64'd9, 5'd31, 1'b0, 1'b0, "xzr");
    check("xzr reg31", rf[31], 64'd0);
    do_op(64'd6, 64'd7, 5'd4, 1'b0, 1'b1, "busy reject");
    check("busy reject value", rf[4], 64'd42);

    // Abort at the 30th RUN cycle.
    @(negedge Clk);
    bus.Start = 1'b1; bus.BusA = 64'd2; bus.BusB = 64'd2; bus.Rd = 5'd5; bus.Op = 1'b0;
    @(negedge Clk);
    bus.Start = 1'b0;
    repeat (29) @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    check("abort Busy", W'(bus.Busy), 64'd0);
    check("abort Done/RegWr", W'({bus.Done, bus.RegWr}), 64'd0);
    check("abort BusW", bus.BusW, 64'd0);
    check("abort RW", W'(bus.RW), 64'd0);
    Reset = 1'b0;
    n_done = 0;
    n_wr = 0;
    repeat (80) begin
      @(negedge Clk);
      if (bus.Done) n_done++;
      if (bus.RegWr) n_wr++;
    end
    check("abort no Done", W'(n_done), 64'd0);
    check("abort no RegWr", W'(n_wr), 64'd0);
    do_op(64'd4, 64'd4, 5'd6, 1'b0, 1'b0, "after abort");

    // Start held high across two operations.
    @(negedge Clk);
    bus.Start = 1'b1; bus.BusA = 64'd10; bus.BusB = 64'd10; bus.Rd = 5'd1; bus.Op = 1'b0;
    cyc = 0; dones = 0; rises = 0; prev_busy = bus.Busy;
    done_t[0] = 0; done_t[1] = 0; rise_t[0] = 0; rise_t[1] = 0;
    while (dones < 2 && cyc < 400) begin
      @(negedge Clk);
      cyc++;
      if (bus.Busy && !prev_busy && rises < 2) begin
        rise_t[rises] = cyc;
        rises++;
      end
      prev_busy = bus.Busy;
      if (bus.Done) begin
        done_t[dones] = cyc;
        if (dones == 0) begin
          check("b2b first BusW", bus.BusW, 64'd100);
          check("b2b first RW", W'(bus.RW), 64'd1);
          bus.BusA = 64'd0; bus.BusB = 64'd123; bus.Rd = 5'd3;
        end else begin
          check("b2b second BusW", bus.BusW, 64'd0);
          check("b2b second RW", W'(bus.RW), 64'd3);
          bus.Start = 1'b0;
        end
        dones++;
      end
    end
    bus.Start = 1'b0;
    check("b2b done count", W'(dones), 64'd2);
    check("b2b done spacing", W'(done_t[1] - done_t[0]), 64'd66);
    check("b2b accept spacing", W'(rise_t[1] - rise_t[0]), 64'd66);
    repeat (2) @(negedge Clk);
    check("b2b regfile r1", rf[1], 64'd100);

    for (int k = 0; k < 8; k++) begin
      do_op({$urandom, $urandom}, {$urandom, $urandom}, 5'($urandom_range(0, 31)),
            1'($urandom_range(0, 1)), 1'b0, "random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
